// File: rtl/store_lane_unit.sv
// Store lane unit: packs byte/half/word stores into byte lanes and runs the req/ack write beat(s).
// Define STORE_SPLIT_UNALIGNED_EN to split misaligned stores into two word beats.
module store_lane_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        st_done,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CntW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

`ifdef STORE_SPLIT_UNALIGNED_EN
  typedef enum logic [2:0] {StIdle, StBeat1, StBeat2, StDone, StErr} state_e;
`else
  typedef enum logic [2:0] {StIdle, StBeat1, StDone, StErr} state_e;
`endif

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      off;
  logic [3:0]      mask;
  logic [31:0]     rep_data;
  logic            natural_misalign;
  logic            reject;
  logic [3:0]      lo_be;
  logic [31:0]     lo_wdata;

  assign off              = st_addr[1:0];
  assign st_ready         = (state_q == StIdle);
  assign natural_misalign = (st_size == 2'b01 && off[0]) || (st_size == 2'b10 && off != 2'b00);
  assign lo_be            = mask << off;

  always_comb begin
    mask     = 4'b1111;
    rep_data = st_data;
    unique case (st_size)
      2'b00: begin
        mask     = 4'b0001;
        rep_data = {4{st_data[7:0]}};
      end
      2'b01: begin
        mask     = 4'b0011;
        rep_data = {2{st_data[15:0]}};
      end
      default: begin
        mask     = 4'b1111;
        rep_data = st_data;
      end
    endcase
  end

`ifdef STORE_SPLIT_UNALIGNED_EN
  logic [7:0]  be8;
  logic [63:0] wdata64;
  logic        two_beat_q;
  logic [31:0] hi_addr_q;
  logic [31:0] hi_wdata_q;
  logic [3:0]  hi_be_q;

  assign be8     = {4'b0000, mask} << off;
  assign wdata64 = {32'b0, st_data} << {off, 3'b000};
  assign reject  = (st_size == 2'b11);
  // Naturally aligned stores keep the replicated pattern; only shifted stores use the window.
  assign lo_wdata = natural_misalign ? wdata64[31:0] : rep_data;
`else
  assign reject   = (st_size == 2'b11) || natural_misalign;
  assign lo_wdata = rep_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      st_done      <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
`ifdef STORE_SPLIT_UNALIGNED_EN
      two_beat_q   <= 1'b0;
      hi_addr_q    <= '0;
      hi_wdata_q   <= '0;
      hi_be_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (st_valid) begin
            if (reject) begin
              state_q      <= StErr;
              misalign_err <= 1'b1;
            end else begin
              state_q   <= StBeat1;
              cnt_q     <= '0;
              mem_req   <= 1'b1;
              mem_addr  <= {st_addr[31:2], 2'b00};
              mem_wdata <= lo_wdata;
              mem_be    <= lo_be;
`ifdef STORE_SPLIT_UNALIGNED_EN
              two_beat_q <= |be8[7:4];
              hi_addr_q  <= {st_addr[31:2], 2'b00} + 32'd4;
              hi_wdata_q <= wdata64[63:32];
              hi_be_q    <= be8[7:4];
`endif
            end
          end
        end
`ifdef STORE_SPLIT_UNALIGNED_EN
        StBeat1, StBeat2: begin
          if (mem_ack && state_q == StBeat1 && two_beat_q) begin
            // Beat 1 is committed; beat 2 gets a fresh timeout window.
            state_q   <= StBeat2;
            cnt_q     <= '0;
            mem_addr  <= hi_addr_q;
            mem_wdata <= hi_wdata_q;
            mem_be    <= hi_be_q;
          end else if (mem_ack) begin
`else
        StBeat1: begin
          if (mem_ack) begin
`endif
            state_q <= StDone;
            mem_req <= 1'b0;
            st_done <= 1'b1;
          end else if (TimeoutEn && cnt_q == CntLast) begin
            state_q <= StErr;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          st_done <= 1'b0;
        end
        StErr: begin
          state_q      <= StIdle;
          misalign_err <= 1'b0;
          bus_err      <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_store_lane_unit.sv
// Directed self-checking bench for store_lane_unit (timeout set to 4 cycles).
module tb_store_lane_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        st_done;
  logic        misalign_err;
  logic        bus_err;

  int errors = 0;
  int checks = 0;
  int n;

  store_lane_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_size      (st_size),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .st_done      (st_done),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    tick();
    st_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_size  = '0;
    mem_ack  = 1'b0;
    #3;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_ready", {31'b0, st_ready}, 32'd1);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_be", {28'b0, mem_be}, 32'd0);
    chk("rst_flags", {29'b0, st_done, misalign_err, bus_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // sb 0x1003, ack two cycles after the request appears
    drive(32'h0000_1003, 32'hAABB_CCDD, 2'b00);
    chk("sb_req", {31'b0, mem_req}, 32'd1);
    chk("sb_ready", {31'b0, st_ready}, 32'd0);
    chk("sb_addr", mem_addr, 32'h0000_1000);
    chk("sb_be", {28'b0, mem_be}, 32'b1000);
    chk("sb_wdata", mem_wdata, 32'hDDDD_DDDD);
    tick();
    chk("sb_req_hold", {31'b0, mem_req}, 32'd1);
    chk("sb_addr_hold", mem_addr, 32'h0000_1000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sb_req_drop", {31'b0, mem_req}, 32'd0);
    chk("sb_done", {31'b0, st_done}, 32'd1);
    tick();
    chk("sb_done_pulse", {31'b0, st_done}, 32'd0);
    chk("sb_ready_back", {31'b0, st_ready}, 32'd1);

    // sh 0x2002; zero-wait memory answers in the cycle after it sees the request
    drive(32'h0000_2002, 32'h1234_BEEF, 2'b01);
    chk("sh_be", {28'b0, mem_be}, 32'b1100);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    n = 1;
    tick();
    mem_ack = 1'b1;
    n++;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 10 && !st_ready; i++) begin
      n++;
      tick();
    end
    chk("sh_ready_low_cycles", n, 32'd3);

    // illegal size is rejected in every build
    drive(32'h0000_3000, 32'h0, 2'b11);
    chk("ill_req", {31'b0, mem_req}, 32'd0);
    chk("ill_mis", {31'b0, misalign_err}, 32'd1);
    tick();
    chk("ill_ready", {31'b0, st_ready}, 32'd1);
    chk("ill_mis_pulse", {31'b0, misalign_err}, 32'd0);

`ifdef STORE_SPLIT_UNALIGNED_EN
    // sw 0xFFFFFFFE: two beats, second wraps to address 0
    drive(32'hFFFF_FFFE, 32'h1122_3344, 2'b10);
    chk("sp1_addr", mem_addr, 32'hFFFF_FFFC);
    chk("sp1_be", {28'b0, mem_be}, 32'b1100);
    chk("sp1_wdata_hi", {16'b0, mem_wdata[31:16]}, 32'h3344);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sp2_req", {31'b0, mem_req}, 32'd1);
    chk("sp2_done_early", {31'b0, st_done}, 32'd0);
    chk("sp2_addr", mem_addr, 32'h0000_0000);
    chk("sp2_be", {28'b0, mem_be}, 32'b0011);
    chk("sp2_wdata_lo", {16'b0, mem_wdata[15:0]}, 32'h1122);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sp_done", {31'b0, st_done}, 32'd1);
    chk("sp_req_drop", {31'b0, mem_req}, 32'd0);
    tick();
    // half at off=1 fits in one beat
    drive(32'h0000_2001, 32'h0000_BEEF, 2'b01);
    chk("sh1_be", {28'b0, mem_be}, 32'b0110);
    chk("sh1_wdata", {16'b0, mem_wdata[23:8]}, 32'hBEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sh1_done", {31'b0, st_done}, 32'd1);
    tick();
`else
    // sw 0x3001: rejected, no request
    drive(32'h0000_3001, 32'h1122_3344, 2'b10);
    chk("mis_req", {31'b0, mem_req}, 32'd0);
    chk("mis_err", {31'b0, misalign_err}, 32'd1);
    chk("mis_ready", {31'b0, st_ready}, 32'd0);
    tick();
    chk("mis_ready_back", {31'b0, st_ready}, 32'd1);
    chk("mis_req_none", {31'b0, mem_req}, 32'd0);
    drive(32'h0000_2001, 32'h0000_BEEF, 2'b01);
    chk("mis_half", {31'b0, misalign_err}, 32'd1);
    tick();
`endif

    // timeout: ack never arrives
    drive(32'h0000_4000, 32'hCAFE_F00D, 2'b10);
    n = 0;
    for (int i = 0; i < 12 && mem_req; i++) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, 32'd4);
    chk("to_bus_err", {31'b0, bus_err}, 32'd1);
    chk("to_no_done", {30'b0, st_done, misalign_err}, 32'd0);
    tick();
    chk("to_ready", {31'b0, st_ready}, 32'd1);
    chk("to_bus_err_pulse", {31'b0, bus_err}, 32'd0);

    // reset in the middle of a beat
    drive(32'h0000_5000, 32'h0, 2'b10);
    chk("rb_req", {31'b0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_req_drop", {31'b0, mem_req}, 32'd0);
    chk("rb_ready", {31'b0, st_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rb_no_flags", {29'b0, st_done, misalign_err, bus_err}, 32'd0);
    drive(32'h0000_6000, 32'hDEAD_BEEF, 2'b10);
    chk("rb_next_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("rb_next_be", {28'b0, mem_be}, 32'b1111);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rb_next_done", {31'b0, st_done}, 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
